// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter that shares one 4-phase SDRAM request/ready port among NUM_PORTS masters.
// Only one transaction is outstanding downstream at a time, and every output is registered.
module sdram_port_arbiter #(
    parameter int NUM_PORTS = 3,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic                          i_clock,
    input  logic                          i_reset_n,
    input  logic [NUM_PORTS-1:0]          i_request,
    input  logic [NUM_PORTS-1:0]          i_rw,
    input  logic [NUM_PORTS*ADDR_W-1:0]   i_address,
    input  logic [NUM_PORTS*DATA_W-1:0]   i_wdata,
    output logic [NUM_PORTS*DATA_W-1:0]   o_rdata,
    output logic [NUM_PORTS-1:0]          o_ready,
    output logic                          o_request,
    output logic                          o_rw,
    output logic [ADDR_W-1:0]             o_address,
    output logic [DATA_W-1:0]             o_wdata,
    input  logic [DATA_W-1:0]             i_rdata,
    input  logic                          i_ready,
    output logic [NUM_PORTS-1:0]          o_grant,
    output logic                          o_busy
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       last_grant_q, last_grant_d;
    logic [NUM_PORTS-1:0]   grant_q, grant_d;
    logic [NUM_PORTS-1:0]   ready_q, ready_d;
    logic                   request_q, request_d;
    logic                   rw_q, rw_d;
    logic                   busy_q, busy_d;
    logic [ADDR_W-1:0]      address_q, address_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;

    logic                   rd_capture;
    logic [NUM_PORTS-1:0]   eligible;
    logic                   win_found;
    logic [IDX_W-1:0]       win_idx;
    logic [IDX_W-1:0]       cand;

    logic [ADDR_W-1:0]      port_addr  [NUM_PORTS];
    logic [DATA_W-1:0]      port_wdata [NUM_PORTS];

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
        assign port_addr[gi]  = i_address[gi*ADDR_W +: ADDR_W];
        assign port_wdata[gi] = i_wdata[gi*DATA_W +: DATA_W];
    end

    // A port already holding o_ready must drop its request before it can compete again.
    assign eligible = i_request & ~ready_q;

    // Round-robin search starting just above the last winner, wrapping at NUM_PORTS.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = last_grant_q;
        for (int k = 0; k < NUM_PORTS; k++) begin
            cand = (cand == IDX_W'(NUM_PORTS - 1)) ? '0 : cand + IDX_W'(1);
            if (!win_found && eligible[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        ready_d      = ready_q;
        request_d    = request_q;
        rw_d         = rw_q;
        address_d    = address_q;
        wdata_d      = wdata_q;
        rd_capture   = 1'b0;

        case (state_q)
            IDLE: begin
                // A still-high i_ready belongs to an earlier handshake; wait it out.
                if (!i_ready && win_found) begin
                    request_d    = 1'b1;
                    rw_d         = i_rw[win_idx];
                    address_d    = port_addr[win_idx];
                    wdata_d      = port_wdata[win_idx];
                    grant_d      = NUM_PORTS'(1) << win_idx;
                    last_grant_d = win_idx;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                if (i_ready) begin
                    rd_capture = !rw_q;
                    ready_d    = grant_q;
                    request_d  = 1'b0;
                    state_d    = RELEASE;
                end
            end
            RELEASE: begin
                if (!i_ready && ((i_request & grant_q) == '0)) begin
                    ready_d = '0;
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= IDX_W'(NUM_PORTS - 1);
            grant_q      <= '0;
            ready_q      <= '0;
            request_q    <= 1'b0;
            rw_q         <= 1'b0;
            busy_q       <= 1'b0;
            address_q    <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            ready_q      <= ready_d;
            request_q    <= request_d;
            rw_q         <= rw_d;
            busy_q       <= busy_d;
            address_q    <= address_d;
            wdata_q      <= wdata_d;
        end
    end

    // Each port keeps its own read-data register; only the owner's slice ever updates.
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
        logic [DATA_W-1:0] rdata_q;

        always_ff @(posedge i_clock or negedge i_reset_n) begin
            if (!i_reset_n) begin
                rdata_q <= '0;
            end else if (rd_capture && grant_q[gi]) begin
                rdata_q <= i_rdata;
            end
        end

        assign o_rdata[gi*DATA_W +: DATA_W] = rdata_q;
    end

    assign o_ready   = ready_q;
    assign o_request = request_q;
    assign o_rw      = rw_q;
    assign o_address = address_q;
    assign o_wdata   = wdata_q;
    assign o_grant   = grant_q;
    assign o_busy    = busy_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: directed scenarios with literal expectations, then randomized
// masters and downstream slave checked every cycle against a transaction-level model.
module tb_sdram_port_arbiter;

    localparam int NP = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic               i_clock   = 1'b0;
    logic               i_reset_n = 1'b0;
    logic [NP-1:0]      i_request = '0;
    logic [NP-1:0]      i_rw      = '0;
    logic [NP*AW-1:0]   i_address = '0;
    logic [NP*DW-1:0]   i_wdata   = '0;
    logic [DW-1:0]      i_rdata   = '0;
    logic               i_ready   = 1'b0;
    logic [NP*DW-1:0]   o_rdata;
    logic [NP-1:0]      o_ready;
    logic               o_request;
    logic               o_rw;
    logic [AW-1:0]      o_address;
    logic [DW-1:0]      o_wdata;
    logic [NP-1:0]      o_grant;
    logic               o_busy;

    sdram_port_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) dut (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_request (i_request),
        .i_rw      (i_rw),
        .i_address (i_address),
        .i_wdata   (i_wdata),
        .o_rdata   (o_rdata),
        .o_ready   (o_ready),
        .o_request (o_request),
        .o_rw      (o_rw),
        .o_address (o_address),
        .o_wdata   (o_wdata),
        .i_rdata   (i_rdata),
        .i_ready   (i_ready),
        .o_grant   (o_grant),
        .o_busy    (o_busy)
    );

    always #5 i_clock = ~i_clock;

    int vectors     = 0;
    int miscompares = 0;
    bit check_en    = 1'b0;

    // Transaction-level model: who owns the port, whether it has been answered, what was latched.
    int             m_owner;
    int             m_last;
    bit             m_served;
    logic           m_rw;
    logic [AW-1:0]  m_addr;
    logic [DW-1:0]  m_wdata;
    logic [DW-1:0]  m_rdata [NP];

    function automatic void model_reset();
        m_owner  = -1;
        m_last   = NP - 1;
        m_served = 1'b0;
        m_rw     = 1'b0;
        m_addr   = '0;
        m_wdata  = '0;
        for (int p = 0; p < NP; p++) m_rdata[p] = '0;
    endfunction

    function automatic void model_step();
        if (!i_reset_n) begin
            model_reset();
            return;
        end
        if (m_owner < 0) begin
            if (!i_ready) begin
                for (int k = 1; k <= NP; k++) begin
                    int p = (m_last + k) % NP;
                    if (i_request[p]) begin
                        m_owner  = p;
                        m_last   = p;
                        m_served = 1'b0;
                        m_rw     = i_rw[p];
                        m_addr   = i_address[p*AW +: AW];
                        m_wdata  = i_wdata[p*DW +: DW];
                        break;
                    end
                end
            end
        end else if (!m_served) begin
            if (i_ready) begin
                if (!m_rw) m_rdata[m_owner] = i_rdata;
                m_served = 1'b1;
            end
        end else if (!i_ready && !i_request[m_owner]) begin
            m_owner  = -1;
            m_served = 1'b0;
        end
    endfunction

    task automatic chk(input string name, input logic [NP*DW-1:0] act, input logic [NP*DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [NP-1:0] eg;
        logic [NP-1:0] er;
        eg = (m_owner >= 0) ? (NP'(1) << m_owner) : '0;
        er = m_served ? eg : '0;
        chk("o_request", o_request, (m_owner >= 0) && !m_served);
        chk("o_grant",   o_grant,   eg);
        chk("o_ready",   o_ready,   er);
        chk("o_busy",    o_busy,    m_owner >= 0);
        chk("o_rw",      o_rw,      m_rw);
        chk("o_address", o_address, m_addr);
        chk("o_wdata",   o_wdata,   m_wdata);
        for (int p = 0; p < NP; p++) chk("o_rdata", o_rdata[p*DW +: DW], m_rdata[p]);
    endtask

    always @(negedge i_clock) begin
        if (check_en) compare_all();
    end

    task automatic tick();
        @(posedge i_clock);
        model_step();
        #1;
    endtask

    task automatic wait_request(input string tag);
        int n = 0;
        while (!o_request && n < 20) begin
            tick();
            n++;
        end
        chk({tag, " request"}, o_request, 1'b1);
    endtask

    task automatic do_txn(input int p, input bit reraise, input string tag);
        wait_request(tag);
        chk({tag, " grant"}, o_grant, NP'(1) << p);
        i_ready = 1'b1;
        i_rdata = $urandom;
        tick();
        chk({tag, " ready"}, o_ready, NP'(1) << p);
        i_request[p] = 1'b0;
        i_ready      = 1'b0;
        tick();
        if (reraise) i_request[p] = 1'b1;
    endtask

    task automatic pulse_reset();
        i_request = '0;
        i_ready   = 1'b0;
        i_reset_n = 1'b0;
        model_reset();
        tick();
        i_reset_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        int mhold [NP];
        int swait;
        int stail;

        model_reset();
        repeat (3) tick();
        chk("reset ctl", {o_request, o_rw, o_busy, o_grant, o_ready}, '0);
        chk("reset address", o_address, '0);
        chk("reset wdata", o_wdata, '0);
        chk("reset rdata", o_rdata, '0);
        i_reset_n = 1'b1;
        check_en  = 1'b1;
        tick();

        // Port 1 read, answered after five cycles
        i_request[1] = 1'b1;
        i_rw[1]      = 1'b0;
        i_address[1*AW +: AW] = 32'h0000_1000;
        tick();
        chk("t1 request", o_request, 1'b1);
        chk("t1 address", o_address, 32'h0000_1000);
        chk("t1 rw", o_rw, 1'b0);
        chk("t1 grant", o_grant, 3'b010);
        repeat (4) tick();
        i_ready = 1'b1;
        i_rdata = 32'hDEAD_BEEF;
        chk("t1 ready early", o_ready, 3'b000);
        tick();
        chk("t1 ready", o_ready, 3'b010);
        chk("t1 rdata", o_rdata, 96'h00000000_DEADBEEF_00000000);
        chk("t1 request low", o_request, 1'b0);
        i_request[1] = 1'b0;
        i_ready      = 1'b0;
        tick();
        chk("t1 idle", {o_busy, o_grant, o_ready}, '0);

        // Port 0 write; read-data slices must not move
        i_request[0] = 1'b1;
        i_rw[0]      = 1'b1;
        i_address[0 +: AW] = 32'h0000_0040;
        i_wdata[0 +: DW]   = 32'h1234_5678;
        tick();
        chk("t2 grant", o_grant, 3'b001);
        chk("t2 rw", o_rw, 1'b1);
        chk("t2 address", o_address, 32'h0000_0040);
        chk("t2 wdata", o_wdata, 32'h1234_5678);
        i_ready = 1'b1;
        i_rdata = 32'hFFFF_FFFF;
        tick();
        chk("t2 ready", o_ready, 3'b001);
        chk("t2 rdata kept", o_rdata, 96'h00000000_DEADBEEF_00000000);
        i_request[0] = 1'b0;
        i_ready      = 1'b0;
        tick();
        chk("t2 ready low", o_ready, 3'b000);

        // Three simultaneous requesters, each re-requesting after service
        pulse_reset();
        i_rw      = 3'b000;
        i_request = 3'b111;
        for (int k = 0; k < 6; k++) do_txn(k % NP, k < 3, $sformatf("t3 txn%0d", k));

        // Port 2 lingers after its ready while port 0 waits
        i_request = 3'b100;
        wait_request("t4 first");
        chk("t4 grant2", o_grant, 3'b100);
        i_ready = 1'b1;
        tick();
        chk("t4 ready2", o_ready, 3'b100);
        i_request[0] = 1'b1;
        i_ready      = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("t4 held grant", o_grant, 3'b100);
        end
        i_request[2] = 1'b0;
        tick();
        chk("t4 released", o_grant, 3'b000);
        tick();
        chk("t4 grant0", o_grant, 3'b001);
        i_ready = 1'b1;
        tick();
        i_request[0] = 1'b0;
        i_ready      = 1'b0;
        tick();

        // Owner changes its address after grant
        i_request[1] = 1'b1;
        i_rw[1]      = 1'b0;
        i_address[1*AW +: AW] = 32'h0000_0100;
        wait_request("t6");
        chk("t6 grant", o_grant, 3'b010);
        i_address[1*AW +: AW] = 32'h0000_0200;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t6 address held", o_address, 32'h0000_0100);
        end
        i_ready = 1'b1;
        tick();
        chk("t6 address final", o_address, 32'h0000_0100);
        i_request[1] = 1'b0;
        i_ready      = 1'b0;
        tick();

        // Reset during ISSUE while downstream keeps i_ready high
        i_request[0] = 1'b1;
        i_rw[0]      = 1'b0;
        i_address[0 +: AW] = 32'h0000_0080;
        wait_request("t5");
        chk("t5 grant", o_grant, 3'b001);
        i_ready = 1'b1;
        #2;
        i_reset_n = 1'b0;
        model_reset();
        #1;
        chk("t5 async ctl", {o_request, o_rw, o_busy, o_grant, o_ready}, '0);
        chk("t5 async address", o_address, '0);
        chk("t5 async rdata", o_rdata, '0);
        tick();
        i_reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t5 stale ready", o_request, 1'b0);
        end
        i_ready = 1'b0;
        tick();
        chk("t5 regrant", o_request, 1'b1);
        chk("t5 regrant port", o_grant, 3'b001);
        i_ready = 1'b1;
        tick();
        i_request[0] = 1'b0;
        i_ready      = 1'b0;
        tick();
        tick();

        // Randomized masters and downstream slave
        swait = 0;
        stail = 0;
        for (int p = 0; p < NP; p++) mhold[p] = 0;
        for (int c = 0; c < 4000; c++) begin
            tick();
            for (int p = 0; p < NP; p++) begin
                if (!i_request[p]) begin
                    if (!o_ready[p] && $urandom_range(0, 3) == 0) begin
                        i_request[p]          = 1'b1;
                        i_rw[p]               = 1'($urandom_range(0, 1));
                        i_address[p*AW +: AW] = $urandom;
                        i_wdata[p*DW +: DW]   = $urandom;
                        mhold[p]              = $urandom_range(0, 3);
                    end
                end else if (o_ready[p]) begin
                    if (mhold[p] == 0) i_request[p] = 1'b0;
                    else mhold[p]--;
                end else if ($urandom_range(0, 5) == 0) begin
                    i_address[p*AW +: AW] = $urandom;
                    i_wdata[p*DW +: DW]   = $urandom;
                end
            end
            if (!i_ready) begin
                if (o_request) begin
                    if (swait == 0) i_ready = 1'b1;
                    else swait--;
                end else begin
                    swait = $urandom_range(0, 4);
                end
            end else begin
                if (!o_request) begin
                    if (stail == 0) i_ready = 1'b0;
                    else stail--;
                end else begin
                    stail = $urandom_range(0, 2);
                end
            end
            i_rdata = $urandom;
        end

        @(negedge i_clock);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
